// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, counter width and error data for mem_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam int CNT_W = 8;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/arb_timeout.sv
// arb_timeout: counts consecutive slave wait cycles and flags the TIMEOUT-th one.
module arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;
  // The current wait cycle is included, so expiry lands on wait cycle number TIMEOUT.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for a shared memory port with slave timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        bus_err
);
  state_t state_q, state_d;
  logic last_q, last_d;
  logic g0, g1, sel_valid, expired, done;
  logic [31:0] rsp;
  assign g0 = state_q == GNT0;
  assign g1 = state_q == GNT1;
  assign sel_valid = g0 ? m0_valid : g1 ? m1_valid : 1'b0;
  arb_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .enable(sel_valid && !mem_ready),
    .expired(expired)
  );
  assign done = sel_valid && (mem_ready || expired);
  // m0 wins a tie when m1 was granted last.
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (m0_valid && (!m1_valid || last_q)) begin
        state_d = GNT0;
        last_d = 1'b0;
      end else if (m1_valid) begin
        state_d = GNT1;
        last_d = 1'b1;
      end
    end else if (!sel_valid || done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  end
  assign grant = {g1, g0};
  assign bus_err = expired;
  assign rsp = expired ? ERR_DATA : mem_rdata;
  assign mem_valid = sel_valid && !expired;
  assign mem_instr = g0 ? m0_instr : g1 ? m1_instr : 1'b0;
  assign mem_addr = g0 ? m0_addr : g1 ? m1_addr : '0;
  assign mem_wdata = g0 ? m0_wdata : g1 ? m1_wdata : '0;
  assign mem_wstrb = g0 ? m0_wstrb : g1 ? m1_wstrb : '0;
  assign m0_ready = g0 && done;
  assign m1_ready = g1 && done;
  assign m0_rdata = g0 ? rsp : '0;
  assign m1_rdata = g1 ? rsp : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter built with TIMEOUT=4.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic m0_valid, m0_instr, m1_valid, m1_instr, mem_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [3:0] m0_wstrb, m1_wstrb;
  logic m0_ready, m1_ready, mem_valid, mem_instr, bus_err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [1:0] grant;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .bus_err(bus_err)
  );
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1; m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    tick; tick;
    total++; if (grant !== 2'b00) $display("FAIL rst_grant got %b want 00", grant); else pass++;
    total++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %b want 0", mem_valid); else pass++;
    total++; if ({m0_ready, m1_ready, bus_err} !== 3'b000) $display("FAIL rst_ready_err got %b want 000", {m0_ready, m1_ready, bus_err}); else pass++;
    reset = 0;
  endtask
  task automatic test_m0_read;
    m0_valid = 1; m0_addr = 32'h40;
    #1;
    total++; if (grant !== 2'b00 || mem_valid !== 1'b0) $display("FAIL rd_same_cycle got %b/%b want 00/0", grant, mem_valid); else pass++;
    tick;
    total++; if (grant !== 2'b01) $display("FAIL rd_grant got %b want 01", grant); else pass++;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40) $display("FAIL rd_mem got %b/%h want 1/00000040", mem_valid, mem_addr); else pass++;
    total++; if (m0_ready !== 1'b0) $display("FAIL rd_wait_ready got %b want 0", m0_ready); else pass++;
    tick;
    mem_ready = 1; mem_rdata = 32'hA5A50001;
    #1;
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hA5A50001) $display("FAIL rd_done got %b/%h want 1/a5a50001", m0_ready, m0_rdata); else pass++;
    total++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0 || bus_err !== 1'b0) $display("FAIL rd_other got %b/%h/%b want 0/0/0", m1_ready, m1_rdata, bus_err); else pass++;
    tick;
    m0_valid = 0; mem_ready = 0;
    total++; if (grant !== 2'b00 || m0_ready !== 1'b0) $display("FAIL rd_idle got %b/%b want 00/0", grant, m0_ready); else pass++;
  endtask
  task automatic test_round_robin;
    reset = 1; tick; reset = 0;
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'h11110000 + i;
      tick;
      if (i % 2 == 0) begin
        total++; if (grant !== 2'b01 || mem_addr !== 32'h10) $display("FAIL rr_grant%0d got %b/%h want 01/00000010", i, grant, mem_addr); else pass++;
        total++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'h11110000 + i) $display("FAIL rr_ready%0d got %b%b/%h want 10", i, m0_ready, m1_ready, m0_rdata); else pass++;
      end else begin
        total++; if (grant !== 2'b10 || mem_addr !== 32'h20) $display("FAIL rr_grant%0d got %b/%h want 10/00000020", i, grant, mem_addr); else pass++;
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== 32'h11110000 + i) $display("FAIL rr_ready%0d got %b%b/%h want 01", i, m0_ready, m1_ready, m1_rdata); else pass++;
      end
      tick;
      total++; if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0) $display("FAIL rr_dead%0d got %b/%b%b want 00/00", i, grant, m0_ready, m1_ready); else pass++;
    end
    m0_valid = 0; m1_valid = 0; mem_ready = 0;
  endtask
  task automatic test_write;
    m1_valid = 1; m1_instr = 0; m1_addr = 32'h100; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
    tick;
    total++; if (grant !== 2'b10) $display("FAIL wr_grant got %b want 10", grant); else pass++;
    total++; if (mem_valid !== 1'b1 || mem_instr !== 1'b0 || mem_addr !== 32'h100) $display("FAIL wr_addr got %b/%b/%h want 1/0/00000100", mem_valid, mem_instr, mem_addr); else pass++;
    total++; if (mem_wdata !== 32'h12345678 || mem_wstrb !== 4'hF) $display("FAIL wr_data got %h/%h want 12345678/f", mem_wdata, mem_wstrb); else pass++;
    mem_ready = 1;
    #1;
    total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) $display("FAIL wr_done got %b%b want 01", m0_ready, m1_ready); else pass++;
    tick;
    m1_valid = 0; m1_wstrb = 0; mem_ready = 0;
  endtask
  task automatic test_timeout;
    m0_valid = 1; m0_addr = 32'h80; mem_rdata = 32'h0BADF00D;
    tick;
    total++; if (bus_err !== 1'b0 || m0_ready !== 1'b0 || grant !== 2'b01) $display("FAIL to_c1 got %b/%b/%b want 0/0/01", bus_err, m0_ready, grant); else pass++;
    tick; tick;
    total++; if (bus_err !== 1'b0 || mem_valid !== 1'b1) $display("FAIL to_c3 got %b/%b want 0/1", bus_err, mem_valid); else pass++;
    tick;
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF) $display("FAIL to_c4_rsp got %b/%h want 1/deadbeef", m0_ready, m0_rdata); else pass++;
    total++; if (bus_err !== 1'b1 || mem_valid !== 1'b0) $display("FAIL to_c4_err got %b/%b want 1/0", bus_err, mem_valid); else pass++;
    tick;
    total++; if (bus_err !== 1'b0 || grant !== 2'b00) $display("FAIL to_after got %b/%b want 0/00", bus_err, grant); else pass++;
    tick; tick; tick; tick;
    mem_ready = 1; mem_rdata = 32'h55;
    #1;
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h55 || bus_err !== 1'b0) $display("FAIL to_race got %b/%h/%b want 1/00000055/0", m0_ready, m0_rdata, bus_err); else pass++;
    tick;
    m0_valid = 0; mem_ready = 0;
  endtask
  task automatic test_reset_mid;
    m1_valid = 1; m1_addr = 32'h200;
    tick;
    total++; if (grant !== 2'b10) $display("FAIL rm_grant got %b want 10", grant); else pass++;
    reset = 1;
    tick;
    mem_ready = 1;
    #1;
    total++; if (grant !== 2'b00 || mem_valid !== 1'b0 || m1_ready !== 1'b0) $display("FAIL rm_cleared got %b/%b/%b want 00/0/0", grant, mem_valid, m1_ready); else pass++;
    reset = 0; m0_valid = 1; mem_ready = 0;
    tick;
    total++; if (grant !== 2'b01) $display("FAIL rm_next got %b want 01", grant); else pass++;
    m0_valid = 0; m1_valid = 0;
    tick;
  endtask
  task automatic test_drop;
    reset = 1; tick; reset = 0;
    m0_valid = 1; m0_addr = 32'h44;
    tick;
    total++; if (grant !== 2'b01) $display("FAIL dr_grant got %b want 01", grant); else pass++;
    m0_valid = 0; m1_valid = 1; m1_addr = 32'h300;
    #1;
    total++; if (m0_ready !== 1'b0 || mem_valid !== 1'b0) $display("FAIL dr_noready got %b/%b want 0/0", m0_ready, mem_valid); else pass++;
    tick;
    total++; if (grant !== 2'b00 || m0_ready !== 1'b0) $display("FAIL dr_idle got %b/%b want 00/0", grant, m0_ready); else pass++;
    tick;
    total++; if (grant !== 2'b10 || mem_addr !== 32'h300) $display("FAIL dr_m1 got %b/%h want 10/00000300", grant, mem_addr); else pass++;
    m1_valid = 0;
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_m0_read;
    test_round_robin;
    test_write;
    test_timeout;
    test_reset_mid;
    test_drop;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
